mem_access_stage: RTL and testbench

Memory-access (MEM) stage of the five-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It performs loads and stores on a data-memory bus with a req/ack handshake, handles byte and halfword lanes, and stalls the front of the pipeline while an access is outstanding. It also presents the control and data fields in the exact form the MEM/WB register latches.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access-size codes and the access FSM states.
package mips_mem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: store replication, byte enables, load extract/extend.
// Purely combinational, zero latency, no backpressure.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] load_data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      wdata      = wd;
      be         = 4'b1111;
      load_data  = rdata;
      misaligned = 1'b0;
      case (size)
         MEM_BYTE: begin
            wdata     = {4{wd[7:0]}};
            be        = 4'b0001 << addr_lo;
            load_data = unsigned_ld ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         MEM_HALF: begin
            wdata      = {2{wd[15:0]}};
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            load_data  = unsigned_ld ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         // Size 11 behaves as a word access.
         default: begin
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: req/ack data-memory access with timeout, feeding the MEM/WB register.
// Adds one stall cycle per access plus one per ack wait cycle; non-memory ops pass through.
module mem_access_stage
   import mips_mem_pkg::*;
#(
   parameter int MAX_WAIT = 15
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [1:0]  mem_size_i,
   input  logic        mem_unsigned_i,
   input  logic        mem_to_reg_i,
   input  logic        reg_write_i,
   input  logic [4:0]  write_register_i,
   input  logic [4:0]  Rd_i,
   input  logic [31:0] pc_plus_4_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] write_data_i,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   output logic        mem_to_reg_o,
   output logic        reg_write_o,
   output logic [4:0]  write_register_o,
   output logic [4:0]  Rd_o,
   output logic [31:0] pc_plus_4_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] read_data_mmry_o,
   output logic        stall_o,
   output logic        misaligned_o,
   output logic        bus_error_o
);

   localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   mem_state_t    state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic [31:0]   rdata_q, rdata_nxt;
   logic          err_q, err_nxt;
   logic          op, misaligned, squash;
   logic [31:0]   load_data;

   assign op = mem_read_i | mem_write_i;

   mem_lane_align u_align (
      .size        (mem_size_i),
      .unsigned_ld (mem_unsigned_i),
      .addr_lo     (alu_result_i[1:0]),
      .wd          (write_data_i),
      .rdata       (rdata_q),
      .wdata       (dmem_wdata_o),
      .be          (dmem_be_o),
      .load_data   (load_data),
      .misaligned  (misaligned)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         rdata_q  <= rdata_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      rdata_nxt    = rdata_q;
      err_nxt      = err_q;
      dmem_req_o   = 1'b0;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      bus_error_o  = 1'b0;
      squash       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (op && misaligned) begin
               misaligned_o = 1'b1;
               squash       = 1'b1;
            end else if (op) begin
               dmem_req_o = 1'b1;
               stall_o    = 1'b1;
               squash     = 1'b1;
               if (dmem_ack_i) begin
                  rdata_nxt = dmem_rdata_i;
                  state_nxt = ST_DONE;
               end else begin
                  wait_cnt_nxt = CW'(1);
                  state_nxt    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            dmem_req_o = 1'b1;
            stall_o    = 1'b1;
            squash     = 1'b1;
            // A late ack on the final wait cycle still wins over the timeout.
            if (dmem_ack_i) begin
               rdata_nxt = dmem_rdata_i;
               state_nxt = ST_DONE;
            end else if (wait_cnt == CW'(MAX_WAIT)) begin
               err_nxt   = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            squash       = err_q;
            bus_error_o  = err_q;
            err_nxt      = 1'b0;
            wait_cnt_nxt = '0;
            state_nxt    = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign dmem_we_o   = dmem_req_o & mem_write_i;
   assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

   assign mem_to_reg_o     = mem_to_reg_i & ~squash;
   assign reg_write_o      = reg_write_i & ~squash;
   assign write_register_o = write_register_i;
   assign Rd_o             = Rd_i;
   assign pc_plus_4_o      = pc_plus_4_i;
   assign alu_result_o     = alu_result_i;
   assign read_data_mmry_o = (mem_read_i & ~mem_write_i) ? load_data : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change on the falling edge, outputs checked 1ns later.
module tb_mem_access_stage;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_i, mem_write_i, mem_unsigned_i, mem_to_reg_i, reg_write_i;
   logic [1:0]  mem_size_i;
   logic [4:0]  write_register_i, Rd_i;
   logic [31:0] pc_plus_4_i, alu_result_i, write_data_i, dmem_rdata_i;
   logic        dmem_ack_i;
   logic        dmem_req_o, dmem_we_o, mem_to_reg_o, reg_write_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o, pc_plus_4_o, alu_result_o, read_data_mmry_o;
   logic [3:0]  dmem_be_o;
   logic [4:0]  write_register_o, Rd_o;
   logic        stall_o, misaligned_o, bus_error_o;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_size_i(mem_size_i),
      .mem_unsigned_i(mem_unsigned_i), .mem_to_reg_i(mem_to_reg_i), .reg_write_i(reg_write_i),
      .write_register_i(write_register_i), .Rd_i(Rd_i), .pc_plus_4_i(pc_plus_4_i),
      .alu_result_i(alu_result_i), .write_data_i(write_data_i),
      .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
      .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
      .write_register_o(write_register_o), .Rd_o(Rd_o), .pc_plus_4_o(pc_plus_4_o),
      .alu_result_o(alu_result_o), .read_data_mmry_o(read_data_mmry_o),
      .stall_o(stall_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
   );

   task automatic clear_inputs();
      mem_read_i = 0; mem_write_i = 0; mem_size_i = MEM_WORD; mem_unsigned_i = 0;
      mem_to_reg_i = 0; reg_write_i = 0; write_register_i = 0; Rd_i = 0;
      pc_plus_4_i = 0; alu_result_i = 0; write_data_i = 0; dmem_rdata_i = 0; dmem_ack_i = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (dmem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", dmem_req_o); else passed++;
      total++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else passed++;
      total++; if (misaligned_o !== 1'b0 || bus_error_o !== 1'b0)
         $display("FAIL rst_exc: got mis=%b berr=%b want 0 0", misaligned_o, bus_error_o); else passed++;
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      alu_result_i = 32'h0000_0040; reg_write_i = 1; mem_to_reg_i = 0;
      write_register_i = 5'd5; Rd_i = 5'd7; pc_plus_4_i = 32'h0000_0104;
      dmem_ack_i = 1'b1;  // stray ack in IDLE must be ignored
      #1;
      total++; if (alu_result_o !== 32'h40 || pc_plus_4_o !== 32'h104)
         $display("FAIL pt_data: got alu=%h pc=%h want 40 104", alu_result_o, pc_plus_4_o); else passed++;
      total++; if (reg_write_o !== 1'b1 || mem_to_reg_o !== 1'b0)
         $display("FAIL pt_ctrl: got rw=%b m2r=%b want 1 0", reg_write_o, mem_to_reg_o); else passed++;
      total++; if (write_register_o !== 5'd5 || Rd_o !== 5'd7)
         $display("FAIL pt_regs: got wr=%0d rd=%0d want 5 7", write_register_o, Rd_o); else passed++;
      total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0 || read_data_mmry_o !== 32'd0)
         $display("FAIL pt_idle: got stall=%b req=%b rd=%h want 0 0 0", stall_o, dmem_req_o, read_data_mmry_o); else passed++;
      @(negedge clk);
      #1;
      total++; if (stall_o !== 1'b0 || reg_write_o !== 1'b1)
         $display("FAIL pt_ack_ignored: got stall=%b rw=%b want 0 1", stall_o, reg_write_o); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_sb();
      @(negedge clk);
      mem_write_i = 1; mem_size_i = MEM_BYTE; alu_result_i = 32'h0000_0013;
      write_data_i = 32'h1234_56AB; dmem_ack_i = 1;
      #1;
      total++; if (dmem_wdata_o !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want ababab ab", dmem_wdata_o); else passed++;
      total++; if (dmem_be_o !== 4'b1000) $display("FAIL sb_be: got %b want 1000", dmem_be_o); else passed++;
      total++; if (dmem_addr_o !== 32'h10) $display("FAIL sb_addr: got %h want 10", dmem_addr_o); else passed++;
      total++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || stall_o !== 1'b1)
         $display("FAIL sb_req: got req=%b we=%b stall=%b want 1 1 1", dmem_req_o, dmem_we_o, stall_o); else passed++;
      @(negedge clk);
      #1;
      total++; if (stall_o !== 1'b0 || dmem_req_o !== 1'b0)
         $display("FAIL sb_done: got stall=%b req=%b want 0 0", stall_o, dmem_req_o); else passed++;
      total++; if (read_data_mmry_o !== 32'd0) $display("FAIL sb_rdata: got %h want 0", read_data_mmry_o); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_sh_lh();
      @(negedge clk);
      mem_write_i = 1; mem_size_i = MEM_HALF; alu_result_i = 32'h0000_0022;
      write_data_i = 32'h1234_ABCD; dmem_ack_i = 1;
      #1;
      total++; if (dmem_wdata_o !== 32'hABCD_ABCD || dmem_be_o !== 4'b1100)
         $display("FAIL sh_lanes: got wdata=%h be=%b want abcdabcd 1100", dmem_wdata_o, dmem_be_o); else passed++;
      @(negedge clk);
      @(negedge clk);
      clear_inputs();
      mem_read_i = 1; mem_size_i = MEM_HALF; alu_result_i = 32'h0000_0002;
      dmem_rdata_i = 32'h8001_0000; dmem_ack_i = 1; reg_write_i = 1;
      @(negedge clk);
      dmem_ack_i = 0; dmem_rdata_i = 32'h0;
      #1;
      total++; if (read_data_mmry_o !== 32'hFFFF_8001) $display("FAIL lh_signed: got %h want ffff8001", read_data_mmry_o); else passed++;
      mem_unsigned_i = 1;
      #1;
      total++; if (read_data_mmry_o !== 32'h0000_8001) $display("FAIL lhu: got %h want 00008001", read_data_mmry_o); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_lb_wait();
      @(negedge clk);
      mem_read_i = 1; mem_size_i = MEM_BYTE; alu_result_i = 32'h0000_0002;
      reg_write_i = 1; mem_to_reg_i = 1; dmem_rdata_i = 32'h0080_0000; dmem_ack_i = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ack_i = (c == 3);
         #1;
         total++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1 || reg_write_o !== 1'b0)
            $display("FAIL lb_stall_c%0d: got stall=%b req=%b rw=%b want 1 1 0", c, stall_o, dmem_req_o, reg_write_o); else passed++;
      end
      @(negedge clk);
      dmem_ack_i = 0; dmem_rdata_i = 32'h0;
      #1;
      total++; if (stall_o !== 1'b0 || reg_write_o !== 1'b1 || mem_to_reg_o !== 1'b1)
         $display("FAIL lb_done: got stall=%b rw=%b m2r=%b want 0 1 1", stall_o, reg_write_o, mem_to_reg_o); else passed++;
      total++; if (read_data_mmry_o !== 32'hFFFF_FF80) $display("FAIL lb_signed: got %h want ffffff80", read_data_mmry_o); else passed++;
      mem_unsigned_i = 1;
      #1;
      total++; if (read_data_mmry_o !== 32'h0000_0080) $display("FAIL lbu: got %h want 00000080", read_data_mmry_o); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      mem_read_i = 1; mem_size_i = MEM_WORD; alu_result_i = 32'h0000_0006;
      reg_write_i = 1; mem_to_reg_i = 1; dmem_ack_i = 0;
      #1;
      total++; if (misaligned_o !== 1'b1 || dmem_req_o !== 1'b0 || stall_o !== 1'b0)
         $display("FAIL mis_pulse: got mis=%b req=%b stall=%b want 1 0 0", misaligned_o, dmem_req_o, stall_o); else passed++;
      total++; if (reg_write_o !== 1'b0 || mem_to_reg_o !== 1'b0)
         $display("FAIL mis_squash: got rw=%b m2r=%b want 0 0", reg_write_o, mem_to_reg_o); else passed++;
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if (misaligned_o !== 1'b0 || stall_o !== 1'b0)
         $display("FAIL mis_clear: got mis=%b stall=%b want 0 0", misaligned_o, stall_o); else passed++;
   endtask

   task automatic test_timeout();
      int req_cycles;
      req_cycles = 0;
      @(negedge clk);
      mem_read_i = 1; mem_size_i = MEM_WORD; alu_result_i = 32'h0000_0020;
      reg_write_i = 1; mem_to_reg_i = 1; dmem_ack_i = 0;
      #1;
      for (int c = 0; c < 40 && dmem_req_o === 1'b1; c++) begin
         req_cycles++;
         @(negedge clk);
         #1;
      end
      total++; if (req_cycles !== 16) $display("FAIL to_req_cycles: got %0d want 16", req_cycles); else passed++;
      total++; if (bus_error_o !== 1'b1 || reg_write_o !== 1'b0 || stall_o !== 1'b0)
         $display("FAIL to_done: got berr=%b rw=%b stall=%b want 1 0 0", bus_error_o, reg_write_o, stall_o); else passed++;
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if (bus_error_o !== 1'b0) $display("FAIL to_pulse: got %b want 0", bus_error_o); else passed++;
   endtask

   task automatic test_reset_in_wait();
      @(negedge clk);
      mem_read_i = 1; mem_size_i = MEM_WORD; alu_result_i = 32'h0; reg_write_i = 1; dmem_ack_i = 0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (dmem_req_o !== 1'b1) $display("FAIL rw_pre: got req=%b want 1", dmem_req_o); else passed++;
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0)
         $display("FAIL rw_abandon: got req=%b stall=%b want 0 0", dmem_req_o, stall_o); else passed++;
      @(negedge clk);
      mem_read_i = 1; mem_size_i = MEM_WORD; alu_result_i = 32'h0; reg_write_i = 1;
      dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
      #1;
      total++; if (dmem_req_o !== 1'b1 || stall_o !== 1'b1)
         $display("FAIL rw_lw_req: got req=%b stall=%b want 1 1", dmem_req_o, stall_o); else passed++;
      @(negedge clk);
      dmem_ack_i = 0; dmem_rdata_i = 32'h0;
      #1;
      total++; if (read_data_mmry_o !== 32'hDEAD_BEEF || reg_write_o !== 1'b1 || bus_error_o !== 1'b0)
         $display("FAIL rw_lw_done: got rd=%h rw=%b berr=%b want deadbeef 1 0", read_data_mmry_o, reg_write_o, bus_error_o); else passed++;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      mem_write_i = 1; mem_size_i = MEM_WORD; alu_result_i = 32'h0000_0100;
      write_data_i = 32'h0BAD_F00D; dmem_ack_i = 1;
      @(negedge clk);
      #1;
      total++; if (dmem_req_o !== 1'b0) $display("FAIL b2b_done: got req=%b want 0", dmem_req_o); else passed++;
      @(negedge clk);
      alu_result_i = 32'h0000_0104; write_data_i = 32'h1111_2222;
      #1;
      total++; if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h104 || dmem_wdata_o !== 32'h1111_2222 || dmem_be_o !== 4'b1111)
         $display("FAIL b2b_second: got req=%b addr=%h wdata=%h be=%b want 1 104 11112222 1111",
                  dmem_req_o, dmem_addr_o, dmem_wdata_o, dmem_be_o); else passed++;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_sb();
      test_sh_lh();
      test_lb_wait();
      test_misaligned();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
